// File: rtl/sha2_block_sequencer.sv
// Byte-stream front end for a SHA-256 core: packs message bytes into 32-bit big-endian
// block-buffer words, appends FIPS 180-4 padding and length, and sequences core starts.
module sha2_block_sequencer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        msg_end,
    output logic        core_we,
    output logic [3:0]  core_waddr,
    output logic [31:0] core_wdata,
    output logic        core_start,
    output logic        core_first,
    input  logic        core_done,
    output logic        busy,
    output logic        msg_done
);

    typedef enum logic [2:0] {StIdle, StFill, StPad, StLen, StStart, StWait} state_e;

    state_e           state;
    logic [5:0]       bp;
    logic [23:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             ended;
    logic             term;
    logic             has_len;

    logic             accept;
    logic             end_seen;
    logic             emit;
    logic [7:0]       emit_byte;
    logic [63:0]      bit_len;
    logic [5:0]       len_shift;

    assign accept    = in_valid & in_ready;
    assign end_seen  = msg_end & in_ready;
    assign bit_len   = 64'(cnt) << 3;
    // Length bytes leave MSB first: byte 56 carries bits [63:56].
    assign len_shift = {3'd7 - bp[2:0], 3'b000};

    always_comb begin
        emit      = 1'b0;
        emit_byte = 8'h00;
        case (state)
            StIdle, StFill: begin
                emit      = accept;
                emit_byte = in_data;
            end
            StPad: begin
                emit      = 1'b1;
                emit_byte = ended ? 8'h00 : 8'h80;
            end
            StLen: begin
                emit      = 1'b1;
                emit_byte = 8'(bit_len >> len_shift);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            bp         <= 6'd0;
            acc        <= 24'd0;
            cnt        <= '0;
            first      <= 1'b1;
            ended      <= 1'b0;
            term       <= 1'b0;
            has_len    <= 1'b0;
            in_ready   <= 1'b0;
            core_we    <= 1'b0;
            core_waddr <= 4'd0;
            core_wdata <= 32'd0;
            core_start <= 1'b0;
            core_first <= 1'b0;
            busy       <= 1'b0;
            msg_done   <= 1'b0;
        end else begin
            core_we    <= 1'b0;
            core_start <= 1'b0;
            core_first <= 1'b0;
            msg_done   <= 1'b0;

            if (emit) begin
                bp <= bp + 6'd1;
                if (bp[1:0] == 2'd3) begin
                    core_we    <= 1'b1;
                    core_waddr <= bp[5:2];
                    core_wdata <= {acc, emit_byte};
                end else begin
                    acc <= {acc[15:0], emit_byte};
                end
            end

            case (state)
                StIdle, StFill: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (cnt != {CNT_W{1'b1}}) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    if (end_seen) begin
                        busy <= 1'b1;
                        term <= 1'b1;
                    end
                    // A full block takes priority; a simultaneous end resumes as PAD after WAIT.
                    if (accept && bp == 6'd63) begin
                        state    <= StStart;
                        in_ready <= 1'b0;
                    end else if (end_seen) begin
                        state    <= StPad;
                        in_ready <= 1'b0;
                    end else begin
                        if (accept) begin
                            state <= StFill;
                        end
                        in_ready <= 1'b1;
                    end
                end
                StPad: begin
                    ended <= 1'b1;
                    if (bp == 6'd55) begin
                        state <= StLen;
                    end else if (bp == 6'd63) begin
                        state <= StStart;
                    end
                end
                StLen: begin
                    if (bp == 6'd63) begin
                        state   <= StStart;
                        has_len <= 1'b1;
                    end
                end
                StStart: begin
                    core_start <= 1'b1;
                    core_first <= first;
                    first      <= 1'b0;
                    state      <= StWait;
                end
                StWait: begin
                    if (core_done) begin
                        if (has_len) begin
                            msg_done <= 1'b1;
                            busy     <= 1'b0;
                            cnt      <= '0;
                            first    <= 1'b1;
                            ended    <= 1'b0;
                            term     <= 1'b0;
                            has_len  <= 1'b0;
                            state    <= StIdle;
                            in_ready <= 1'b1;
                        end else if (term) begin
                            state <= StPad;
                        end else begin
                            state    <= StFill;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_block_sequencer.sv
// Self-checking bench for sha2_block_sequencer: random messages against a padded-stream model,
// an emulated compression core with random latency, and reset/stray-done scenarios.
module tb_sha2_block_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        msg_end;
    logic        core_we;
    logic [3:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        core_start;
    logic        core_first;
    logic        core_done;
    logic        busy;
    logic        msg_done;

    int          checks;
    int          errors;
    logic [7:0]  msg[$];
    logic [7:0]  exp_q[$];
    int          exp_blocks;
    logic [31:0] wbuf[16];
    bit          core_en;
    int          stray_cnt;

    sha2_block_sequencer #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .msg_end    (msg_end),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata),
        .core_start (core_start),
        .core_first (core_first),
        .core_done  (core_done),
        .busy       (busy),
        .msg_done   (msg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compression core stand-in: done pulse 1..8 cycles after start, or a stray pulse on request.
    initial begin
        int cd;
        int seen;
        cd = 0;
        seen = 0;
        core_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else if (stray_cnt != seen) begin
                seen = stray_cnt;
                core_done = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) core_done = 1'b1;
            end else if (core_start && core_en) begin
                cd = $urandom_range(1, 8);
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Padded stream: message, 0x80, zeros up to 56 mod 64, then 64-bit bit length MSB first.
    function automatic void build_exp();
        logic [63:0] bl;
        exp_q.delete();
        foreach (msg[i]) exp_q.push_back(msg[i]);
        exp_q.push_back(8'h80);
        while (exp_q.size() % 64 != 56) exp_q.push_back(8'h00);
        bl = 64'(msg.size()) << 3;
        for (int k = 7; k >= 0; k--) exp_q.push_back(bl[8*k +: 8]);
        exp_blocks = exp_q.size() / 64;
    endfunction

    function automatic logic [31:0] exp_word(input int b, input int w);
        int base;
        base = b * 64 + w * 4;
        return {exp_q[base], exp_q[base+1], exp_q[base+2], exp_q[base+3]};
    endfunction

    task automatic rand_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic abc_msg();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_core_we"}, core_we, 1'b0);
        chk32({tag, "_core_waddr"}, {28'd0, core_waddr}, 32'd0);
        chk32({tag, "_core_wdata"}, core_wdata, 32'd0);
        chk1({tag, "_core_start"}, core_start, 1'b0);
        chk1({tag, "_core_first"}, core_first, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_msg_done"}, msg_done, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        while (!in_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk1({tag, "_ready_timeout"}, in_ready, 1'b1);
        @(negedge clk);
    endtask

    // mode: 0 no end, 1 msg_end with the last byte, 2 separate msg_end strobe.
    task automatic drive(input int mode);
        for (int i = 0; i < msg.size(); i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = msg[i];
            msg_end  = (mode == 1 && i == msg.size() - 1);
            wait_ready("byte");
            if (i == 0) chk1("busy_after_first_byte", busy, 1'b1);
            in_valid = 1'b0;
            msg_end  = 1'b0;
        end
        if (mode == 2) begin
            msg_end = 1'b1;
            wait_ready("end");
            msg_end = 1'b0;
        end
    endtask

    task automatic watch(input string name, input bit until_done);
        int          blk;
        int          t;
        bit          outst;
        bit          prev_done;
        bit          prev_we15;
        bit          fin;
        logic [15:0] mask;
        blk = 0; t = 0; outst = 0; prev_done = 0; prev_we15 = 0; fin = 0; mask = 16'h0;
        while (!fin && t < 4000) begin
            @(negedge clk);
            t++;
            if (core_start) begin
                chk1({name, "_start_after_w15"}, prev_we15, 1'b1);
                chk1({name, "_single_outstanding"}, outst, 1'b0);
                chk1({name, "_core_first"}, core_first, blk == 0);
                chk1({name, "_block_in_range"}, blk < exp_blocks, 1'b1);
                chk32({name, "_words_written"}, {16'h0, mask}, 32'h0000ffff);
                if (blk < exp_blocks) begin
                    for (int w = 0; w < 16; w++)
                        chk32($sformatf("%s_b%0d_w%0d", name, blk, w), wbuf[w], exp_word(blk, w));
                end
                mask  = 16'h0;
                blk++;
                outst = 1'b1;
                if (!until_done) fin = 1'b1;
            end
            if (core_we) begin
                wbuf[core_waddr] = core_wdata;
                mask[core_waddr] = 1'b1;
            end
            prev_we15 = core_we && core_waddr == 4'd15;
            if (msg_done) begin
                chk1({name, "_done_after_core_done"}, prev_done, 1'b1);
                chk32({name, "_block_count"}, 32'(blk), 32'(exp_blocks));
                fin = 1'b1;
            end
            if (core_done) outst = 1'b0;
            prev_done = core_done;
        end
        if (!fin) chk1({name, "_watch_timeout"}, fin, 1'b1);
    endtask

    task automatic run_msg(input string name, input int mode);
        build_exp();
        fork
            drive(mode);
            watch(name, 1'b1);
        join
        chk1({name, "_busy_clear"}, busy, 1'b0);
        chk1({name, "_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic quiet_after_reset(input string tag);
        rst_n = 1'b1;
        stray_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1({tag, "_no_start"}, core_start, 1'b0);
            chk1({tag, "_no_done"}, msg_done, 1'b0);
            chk1({tag, "_not_busy"}, busy, 1'b0);
        end
        chk1({tag, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        msg_end   = 1'b0;
        core_en   = 1'b1;
        stray_cnt = 0;

        #2 rst_n = 1'b0;
        #1 chk_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk1("ready_low_at_release", in_ready, 1'b0);
        @(negedge clk);
        chk1("ready_after_release", in_ready, 1'b1);

        abc_msg();
        run_msg("abc", 1);
        chk32("abc_w0_kat", wbuf[0], 32'h61626380);
        chk32("abc_w15_kat", wbuf[15], 32'h00000018);

        msg.delete();
        run_msg("empty", 2);
        chk32("empty_w0_kat", wbuf[0], 32'h80000000);

        rand_msg(55);
        run_msg("len55", 1);
        chk32("len55_w13_lsb", {24'd0, wbuf[13][7:0]}, 32'h00000080);
        chk32("len55_w15_kat", wbuf[15], 32'h000001b8);

        rand_msg(56);
        run_msg("len56", 2);
        chk32("len56_b2_w0", wbuf[0], 32'h00000000);
        chk32("len56_b2_w15", wbuf[15], 32'h000001c0);

        rand_msg(64);
        run_msg("len64", 1);
        chk32("len64_b2_w0", wbuf[0], 32'h80000000);
        chk32("len64_b2_w15", wbuf[15], 32'h00000200);

        for (int k = 0; k < 8; k++) begin
            int n;
            int mode;
            n = $urandom_range(0, 150);
            mode = (n == 0) ? 2 : $urandom_range(1, 2);
            rand_msg(n);
            run_msg($sformatf("rand%0d_len%0d", k, n), mode);
        end

        // Reset in the middle of filling a block.
        rand_msg(20);
        drive(0);
        chk1("midfill_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset("midfill_rst");
        repeat (2) @(negedge clk);
        quiet_after_reset("midfill_stray");
        abc_msg();
        run_msg("abc_after_fill_rst", 1);

        // Reset while waiting on the core.
        abc_msg();
        build_exp();
        core_en = 1'b0;
        fork
            drive(1);
            watch("abc_wait", 1'b0);
        join
        @(negedge clk);
        chk1("wait_busy", busy, 1'b1);
        chk1("wait_not_ready", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset("wait_rst");
        repeat (2) @(negedge clk);
        core_en = 1'b1;
        quiet_after_reset("wait_stray");
        abc_msg();
        run_msg("abc_after_wait_rst", 1);
        chk32("abc_after_wait_rst_w0", wbuf[0], 32'h61626380);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
